// File: rtl/reg_bank_reader.sv
// ---------------------------------------------------------------------------
// reg_bank_reader
//
// Purpose:
//   Streams a burst of consecutive register values out of a bank of NREGS
//   load/clear registers. The registers' Q outputs arrive as one flat vector.
//   A read command gives a start index and a beat count. Each beat is
//   presented on data_out/data_valid and is consumed when data_ready is high.
//   The burst wraps from index NREGS-1 back to index 0.
//
// Ports:
//   clock       rising-edge clock
//   clear       synchronous active-low reset (0 = reset)
//   regs_flat   register i occupies bits [i*size +: size]
//   rd_start    read command strobe, sampled only while idle
//   rd_addr     first register index of the burst
//   rd_count    number of beats requested (clamped to NREGS)
//   busy        high while a burst is in progress
//   data_out    current beat value (snapshot taken when fetched)
//   data_valid  data_out holds a valid beat
//   data_ready  consumer accepts the beat when data_valid && data_ready
//   done        one-cycle pulse at the end of a burst or a rejected command
//   err         one-cycle pulse alongside done when the command was rejected
// ---------------------------------------------------------------------------
module reg_bank_reader #(
  parameter int size  = 8,
  parameter int NREGS = 8,
  parameter int ABITS = 3
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [NREGS*size-1:0] regs_flat,
  input  logic                  rd_start,
  input  logic [ABITS-1:0]      rd_addr,
  input  logic [ABITS:0]        rd_count,
  output logic                  busy,
  output logic [size-1:0]       data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  done,
  output logic                  err
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // NREGS expressed in the counter width; ABITS+1 bits always hold NREGS
  // because 2**ABITS >= NREGS.
  localparam logic [ABITS:0]   NREGS_W  = NREGS[ABITS:0];
  localparam logic [ABITS-1:0] LAST_IDX = ABITS'(NREGS - 1);
  localparam logic [ABITS:0]   CNT_ZERO = '0;
  localparam logic [ABITS:0]   CNT_ONE  = (ABITS+1)'(1);

  // Unpack the flat bank into an indexable array.
  logic [size-1:0] reg_arr [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_unpack
      assign reg_arr[gi] = regs_flat[gi*size +: size];
    end
  endgenerate

  state_t          state_q, state_d;
  logic [ABITS-1:0] ptr_q, ptr_d;
  logic [ABITS:0]   remaining_q, remaining_d;
  logic [size-1:0]  data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Next pointer with wrap at the last implemented register, not at 2**ABITS.
  logic [ABITS-1:0] ptr_next;
  assign ptr_next = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    remaining_d  = remaining_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rd_start) begin
          if ({1'b0, rd_addr} >= NREGS_W) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (rd_count == CNT_ZERO) begin
            done_d = 1'b1;
          end else begin
            data_out_d   = reg_arr[rd_addr];
            data_valid_d = 1'b1;
            busy_d       = 1'b1;
            ptr_d        = rd_addr;
            remaining_d  = (rd_count > NREGS_W) ? NREGS_W : rd_count;
            state_d      = SEND;
          end
        end
      end

      SEND: begin
        // data_out is a snapshot; while stalled it is simply held.
        if (data_ready) begin
          if (remaining_q > CNT_ONE) begin
            ptr_d       = ptr_next;
            data_out_d  = reg_arr[ptr_next];
            remaining_d = remaining_q - CNT_ONE;
          end else begin
            data_valid_d = 1'b0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            remaining_d  = CNT_ZERO;
            state_d      = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      remaining_q  <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      remaining_q  <= remaining_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/reg_bank_reader.md
Name: reg_bank_reader

Overview:
Read-side companion to the DFF_reg load/clear register.
- Takes the Q outputs of a bank of NREGS DFF_reg instances as one flat vector.
- On a read command, streams a burst of consecutive register values to a consumer over a valid/ready handshake.
- Sits between the processor's register bank and any consumer that needs register contents: the debug/display path or bus write-back.

Parameters:
size, 8, width of each register
NREGS, 8, number of registers in the bank (2..16)
ABITS, 3, width of rd_addr; must satisfy 2**ABITS >= NREGS

Ports:
clock  input  1  rising-edge clock
clear  input  1  synchronous active-low reset (0 = reset)
regs_flat  input  NREGS*size  register i occupies bits [i*size +: size]
rd_start  input  1  read command strobe, sampled only in IDLE
rd_addr  input  ABITS  first register index of the burst
rd_count  input  ABITS+1  number of beats requested
busy  output  1  high while a burst is in progress
data_out  output  size  current beat value
data_valid  output  1  data_out holds a valid beat
data_ready  input  1  consumer accepts the beat when data_valid && data_ready
done  output  1  one-cycle pulse at burst end
err  output  1  one-cycle pulse alongside done when the command was rejected

Behaviour:
- Reset: clear==0 at a rising edge forces state=IDLE and busy=0, data_out=0, data_valid=0, done=0, err=0, ptr=0, remaining=0. This applies mid-burst; the burst is dropped with no done pulse.
- States: IDLE, SEND.
- IDLE, rd_start=0: all outputs hold; done and err are 0.
- IDLE, rd_start=1 and rd_addr>=NREGS: stay IDLE; next cycle done=1, err=1; no beat.
- IDLE, rd_start=1 and rd_count==0: stay IDLE; next cycle done=1, err=0; no beat.
- IDLE, rd_start=1, valid command:
  - eff = min(rd_count, NREGS).
  - data_out <= regs_flat[rd_addr], data_valid <= 1, busy <= 1.
  - ptr <= rd_addr, remaining <= eff; go to SEND.
  - Latency: first beat valid one cycle after rd_start is sampled.
- SEND, data_ready=0: data_out and data_valid hold. The beat value is the snapshot taken at fetch; later changes to regs_flat do not alter it.
- SEND, data_ready=1, remaining>1:
  - ptr <= (ptr==NREGS-1) ? 0 : ptr+1.
  - data_out <= regs_flat[new ptr], remaining <= remaining-1.
  - data_valid stays 1, giving one beat per cycle back-to-back.
- SEND, data_ready=1, remaining==1: data_valid <= 0, busy <= 0, done <= 1 for exactly one cycle; go to IDLE.
- rd_start during SEND is ignored; it is neither queued nor an error.
- A new rd_start in the cycle done is high is accepted normally, because the state is already IDLE.
- Wrap: a burst crossing index NREGS-1 continues at index 0.
- Counter widths: remaining is ABITS+1 bits.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: hold clear=0 for 2 cycles with rd_start=1 → busy=0, data_valid=0, data_out=8'h00, done=0 throughout.
- Single beat:
  - Stimulus: regs = {8'h07..8'h00} (reg i = i), rd_addr=3, rd_count=1, data_ready=1.
  - Response: next cycle data_out=8'h03, data_valid=1. Following cycle data_valid=0, done=1 for one cycle.
- Wrap burst:
  - Stimulus: rd_addr=6, rd_count=4, data_ready=1.
  - Response: beats 8'h06, 8'h07, 8'h00, 8'h01 on consecutive cycles; done one cycle after the last beat.
- Backpressure:
  - Stimulus: rd_addr=0, rd_count=2; data_ready=0 for 3 cycles; change reg0 to 8'hA5 during the stall.
  - Response: data_out stays 8'h00 and valid for 3 cycles. Then with data_ready=1: 8'h00 accepted, 8'h01 next, then done.
- Boundaries:
  - rd_count=0 → done=1, err=0, no valid beat.
  - rd_addr=3'd7 with NREGS=6 → done=1, err=1.
  - rd_count=12 with NREGS=8 → exactly 8 beats.
- Abort and ignore:
  - Stimulus: start a 5-beat burst; assert rd_start with another address mid-burst; then pull clear=0 after beat 2.
  - Response: the mid-burst rd_start has no effect. The cycle after clear=0: busy=0, data_valid=0, and done never pulses.
